vram_mp: RTL and testbench

Parametrised, multi-channel VDC video RAM for the HuC6270 model. It holds a single-port word array and arbitrates between NUM_CH requesters, such as CPU port, BG fetch and SAT DMA. Each cycle it grants at most one access under fixed priority. After reset it clears the whole array with a hardware sequencer, and software can restart that clear at runtime. It replaces the single-requester VRAM model.

---
 rtl/vram_pkg.sv | 21 ++
 rtl/vram_if.sv | 29 ++
 rtl/vram_bank.sv | 51 +++++
 rtl/vram_mp.sv | 139 +++++++++++++
 tb/tb_vram_mp.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// VRAM shared types, defaults and helpers.
// Imported by the interface, the bank and the multi-port top.
package vram_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } vram_state_t;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 16;
  localparam int VRAM_MAX_CH = 32;

  // Isolate the lowest set bit: channel 0 wins.
  function automatic logic [VRAM_MAX_CH-1:0] prio_onehot(
    input logic [VRAM_MAX_CH-1:0] req
  );
    return req & (-req);
  endfunction

endpackage

// File: rtl/vram_if.sv
// VRAM requester bus: packed per-channel req/we/addr/wdata
// from requesters (master), gnt/rvalid/rdata back (slave).
interface vram_if
  import vram_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH-1:0]        rvalid;
  logic [DATA_W-1:0]        rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/vram_bank.sv
// Single-port synchronous word RAM, 1-cycle registered read.
// Ports: en_i/we_i/addr_i/wdata_i in, rdata_o (holds between reads).
module vram_bank
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

`ifdef VRAM_BRAM
  vram_bram_wrap #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bram (
    .clock  (clock),
    .reset_N(reset_N),
    .en_i   (en_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o)
  );
`else
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en_i && we_i)
      mem_q[addr_i] <= wdata_i;
  end

  // Output only moves on reads, so it holds across writes.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N)
      rdata_q <= '0;
    else if (en_i && !we_i)
      rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/vram_mp.sv
// Multi-channel VRAM: fixed-priority arbiter, clear sequencer.
// Ports: clock, reset_N, bus (vram_if.slave), clr_req_i, busy_o.
module vram_mp
  import vram_pkg::*;
#(
  parameter int ADDR_W         = VRAM_ADDR_W,
  parameter int DATA_W         = VRAM_DATA_W,
  parameter int NUM_CH         = 3,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic  clock,
  input  logic  reset_N,
  vram_if.slave bus,
  input  logic  clr_req_i,
  output logic  busy_o
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  vram_state_t       state_q;
  logic [ADDR_W-1:0] caddr_q;
  logic              busy_q;
  logic [NUM_CH-1:0] gnt;
  logic [NUM_CH-1:0] rv_q;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;
  logic              bank_en;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wd;
  logic [DATA_W-1:0] bank_rdata;

  // A clear request steals its own cycle from the requesters.
  assign gnt = (state_q == RUN && !clr_req_i)
             ? NUM_CH'(prio_onehot(VRAM_MAX_CH'(bus.req)))
             : '0;
  assign bus.gnt = gnt;
  assign busy_o  = busy_q;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      caddr_q <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else if (clr_req_i) begin
      state_q <= CLEAR;
      caddr_q <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == CLEAR) begin
      caddr_q <= caddr_q + ADDR_W'(1);
      if (caddr_q == LAST) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_wd   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_we   = bus.we[i];
        sel_addr = bus.addr[i*ADDR_W +: ADDR_W];
        sel_wd   = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bank_en   = |gnt;
    bank_we   = sel_we;
    bank_addr = sel_addr;
    bank_wd   = sel_wd;
    if (state_q == CLEAR) begin
      bank_en   = 1'b1;
      bank_we   = 1'b1;
      bank_addr = caddr_q;
      bank_wd   = '0;
    end
  end

  vram_bank #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bank (
    .clock  (clock),
    .reset_N(reset_N),
    .en_i   (bank_en),
    .we_i   (bank_we),
    .addr_i (bank_addr),
    .wdata_i(bank_wd),
    .rdata_o(bank_rdata)
  );

  // Channel tag travels alongside the read data.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N)
      rv_q <= '0;
    else
      rv_q <= gnt & ~bus.we;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [NUM_CH-1:0] rv2_q;
      logic [DATA_W-1:0] rd2_q;

      always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
          rv2_q <= '0;
          rd2_q <= '0;
        end else begin
          rv2_q <= rv_q;
          if (|rv_q)
            rd2_q <= bank_rdata;
        end
      end

      assign bus.rvalid = rv2_q;
      assign bus.rdata  = rd2_q;
    end else begin : g_lat1
      assign bus.rvalid = rv_q;
      assign bus.rdata  = bank_rdata;
    end
  endgenerate

`ifdef VRAM_TRACE
  always @(posedge clock) begin
    if (reset_N && state_q == RUN && bank_en && bank_we)
      $display("vram wr [%h] <= %h", bank_addr, bank_wd);
  end
`endif

endmodule

// File: tb/tb_vram_mp.sv
// Bench for vram_mp: two clear-on-reset DUTs (RD_LAT 1 and 2)
// against a behavioural model, plus a no-clear DUT.
module tb_vram_mp;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int NC    = 3;
  localparam int DEPTH = 16;

  logic clock   = 1'b0;
  logic reset_N = 1'b0;
  always #5 clock = ~clock;

  logic [NC-1:0]    req   = '0;
  logic [NC-1:0]    we    = '0;
  logic [NC*AW-1:0] addr  = '0;
  logic [NC*DW-1:0] wdata = '0;
  logic             clr   = 1'b0;

  logic [NC-1:0]    reqc   = '0;
  logic [NC-1:0]    wec    = '0;
  logic [NC*AW-1:0] addrc  = '0;
  logic [NC*DW-1:0] wdatac = '0;

  logic busy_a, busy_b, busy_c;

  vram_if #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  vram_if #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW)) ifb ();
  vram_if #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW)) ifc ();

  assign ifa.req   = req;
  assign ifa.we    = we;
  assign ifa.addr  = addr;
  assign ifa.wdata = wdata;
  assign ifb.req   = req;
  assign ifb.we    = we;
  assign ifb.addr  = addr;
  assign ifb.wdata = wdata;
  assign ifc.req   = reqc;
  assign ifc.we    = wec;
  assign ifc.addr  = addrc;
  assign ifc.wdata = wdatac;

  vram_mp #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC),
    .RD_LAT(1), .CLEAR_ON_RESET(1)
  ) ua (
    .clock(clock), .reset_N(reset_N), .bus(ifa),
    .clr_req_i(clr), .busy_o(busy_a)
  );

  vram_mp #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC),
    .RD_LAT(2), .CLEAR_ON_RESET(1)
  ) ub (
    .clock(clock), .reset_N(reset_N), .bus(ifb),
    .clr_req_i(clr), .busy_o(busy_b)
  );

  vram_mp #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC),
    .RD_LAT(1), .CLEAR_ON_RESET(0)
  ) uc (
    .clock(clock), .reset_N(reset_N), .bus(ifc),
    .clr_req_i(1'b0), .busy_o(busy_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: memory array, words left to clear,
  // and per-DUT delivery slots keyed by due cycle.
  logic [DW-1:0] mmem [DEPTH];
  int            left = DEPTH;
  int            cyc  = 0;
  int            lat [2] = '{1, 2};
  logic          sv  [2][4];
  logic [NC-1:0] sch [2][4];
  logic [DW-1:0] sd  [2][4];
  logic [NC-1:0] exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  logic [NC-1:0] last_gnt = '0;

  function automatic logic [NC-1:0] low_bit(input logic [NC-1:0] r);
    for (int i = 0; i < NC; i++)
      if (r[i]) return NC'(1) << i;
    return '0;
  endfunction

  function automatic logic [NC-1:0] mgnt();
    if (left > 0 || clr) return '0;
    return low_bit(req);
  endfunction

  function automatic int idx(input logic [NC-1:0] g);
    for (int i = 0; i < NC; i++)
      if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    left     = DEPTH;
    cyc      = 0;
    last_gnt = '0;
    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = '0;
      exp_rd[k] = '0;
      for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [NC-1:0] g;
    logic [AW-1:0] ma;
    int ch;
    int s;
    g        = mgnt();
    last_gnt = g;
    cyc++;
    if (clr) begin
      left = DEPTH;
    end else if (left > 0) begin
      left--;
      if (left == 0)
        for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
    end else if (g != '0) begin
      ch = idx(g);
      ma = addr[ch*AW +: AW];
      if (we[ch]) begin
        mmem[ma] = wdata[ch*DW +: DW];
      end else begin
        for (int k = 0; k < 2; k++) begin
          s = (cyc + lat[k] - 1) % 4;
          sv[k][s]  = 1'b1;
          sch[k][s] = g;
          sd[k][s]  = mmem[ma];
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      s = cyc % 4;
      if (sv[k][s]) begin
        exp_rv[k] = sch[k][s];
        exp_rd[k] = sd[k][s];
        sv[k][s]  = 1'b0;
      end else begin
        exp_rv[k] = '0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_N);
      if (!reset_N) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [NC-1:0] g;
    forever begin
      @(negedge clock);
      g = mgnt();
      chk("gnt_a",    32'(ifa.gnt),    32'(g));
      chk("gnt_b",    32'(ifb.gnt),    32'(g));
      chk("busy_a",   32'(busy_a),     32'(left > 0));
      chk("busy_b",   32'(busy_b),     32'(left > 0));
      chk("rvalid_a", 32'(ifa.rvalid), 32'(exp_rv[0]));
      chk("rvalid_b", 32'(ifb.rvalid), 32'(exp_rv[1]));
      chk("rdata_a",  32'(ifa.rdata),  32'(exp_rd[0]));
      chk("rdata_b",  32'(ifb.rdata),  32'(exp_rd[1]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int i, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]           = r;
    we[i]            = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic set_c(input int i, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqc[i]            = r;
    wec[i]             = w;
    addrc[i*AW +: AW]  = a;
    wdatac[i*DW +: DW] = d;
  endtask

  // Counts busy cycles on DUT A from the next falling edge on;
  // `seen` cycles were already observed by the caller.
  task automatic count_busy(input string nm, input int seen);
    int n;
    n = seen;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (!busy_a) break;
      n++;
    end
    chk(nm, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    // Reset, with channel 0 already requesting a read of 5.
    set_ch(0, 1'b1, 1'b0, 4'h5, 16'h0);
    repeat (3) @(posedge clock);
    #1 reset_N = 1'b1;
    count_busy("t1_busy_len", 0);
    chk("t1_gnt", 32'(ifa.gnt), 32'h1);
    tick();
    set_ch(0, 1'b0, 1'b0, 4'h0, 16'h0);
    @(negedge clock);
    chk("t1_rv_a", 32'(ifa.rvalid), 32'h1);
    chk("t1_rd_a", 32'(ifa.rdata),  32'h0);
    @(negedge clock);
    chk("t1_rv_b", 32'(ifb.rvalid), 32'h1);

    // Write on ch1 then read-after-write on ch0.
    tick();
    set_ch(1, 1'b1, 1'b1, 4'h2, 16'hBEEF);
    @(negedge clock);
    chk("t2_gnt_w", 32'(ifa.gnt), 32'h2);
    tick();
    set_ch(1, 1'b0, 1'b0, 4'h0, 16'h0);
    set_ch(0, 1'b1, 1'b0, 4'h2, 16'h0);
    tick();
    set_ch(0, 1'b0, 1'b0, 4'h0, 16'h0);
    @(negedge clock);
    chk("t2_rv_a", 32'(ifa.rvalid), 32'h1);
    chk("t2_rd_a", 32'(ifa.rdata),  32'hBEEF);
    @(negedge clock);
    chk("t2_rv_b", 32'(ifb.rvalid), 32'h1);
    chk("t2_rd_b", 32'(ifb.rdata),  32'hBEEF);
    chk("t2_hold_rv_a", 32'(ifa.rvalid), 32'h0);
    chk("t2_hold_rd_a", 32'(ifa.rdata),  32'hBEEF);

    // All three channels read at once, each drops after grant.
    tick();
    set_ch(0, 1'b1, 1'b0, 4'h2, 16'h0);
    set_ch(1, 1'b1, 1'b0, 4'h1, 16'h0);
    set_ch(2, 1'b1, 1'b0, 4'h2, 16'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("t3_gnt", 32'(ifa.gnt),
          (c < 3) ? (32'h1 << c) : 32'h0);
      chk("t3_rv_a", 32'(ifa.rvalid),
          (c >= 1 && c <= 3) ? (32'h1 << (c - 1)) : 32'h0);
      chk("t3_rv_b", 32'(ifb.rvalid),
          (c >= 2) ? (32'h1 << (c - 2)) : 32'h0);
      if (c == 1) chk("t3_rd_a", 32'(ifa.rdata), 32'hBEEF);
      tick();
      if (c < 3) set_ch(c, 1'b0, 1'b0, 4'h0, 16'h0);
    end

    // Clear requested right after a ch2 read grant.
    set_ch(2, 1'b1, 1'b0, 4'h2, 16'h0);
    @(negedge clock);
    chk("t4_gnt", 32'(ifa.gnt), 32'h4);
    tick();
    set_ch(2, 1'b0, 1'b0, 4'h0, 16'h0);
    set_ch(0, 1'b1, 1'b0, 4'h2, 16'h0);
    clr = 1'b1;
    @(negedge clock);
    chk("t4_gnt_clr", 32'(ifa.gnt),    32'h0);
    chk("t4_rv_a",    32'(ifa.rvalid), 32'h4);
    chk("t4_rd_a",    32'(ifa.rdata),  32'hBEEF);
    tick();
    clr = 1'b0;
    @(negedge clock);
    chk("t4_rv_b",   32'(ifb.rvalid), 32'h4);
    chk("t4_rd_b",   32'(ifb.rdata),  32'hBEEF);
    chk("t4_busy_r", 32'(busy_a),     32'h1);
    count_busy("t4_busy_len", 1);
    chk("t4_gnt_run", 32'(ifa.gnt), 32'h1);
    tick();
    set_ch(0, 1'b0, 1'b0, 4'h0, 16'h0);
    @(negedge clock);
    chk("t4_wiped_rv", 32'(ifa.rvalid), 32'h1);
    chk("t4_wiped_rd", 32'(ifa.rdata),  32'h0);
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      set_ch(0, 1'b1, 1'b0, AW'(a), 16'h0);
      tick();
    end
    set_ch(0, 1'b0, 1'b0, 4'h0, 16'h0);
    repeat (3) tick();

    // Reset in the middle of a clear at caddr 7.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    reset_N = 1'b0;
    @(negedge clock);
    chk("t6_rd_c_rst",   32'(ifc.rdata),  32'h0);
    chk("t6_busy_c_rst", 32'(busy_c),     32'h0);
    chk("t5_busy_rst",   32'(busy_a),     32'h1);
    repeat (2) tick();
    reset_N = 1'b1;
    count_busy("t5_reclear", 0);

    // Reset while a read is in flight.
    tick();
    set_ch(0, 1'b1, 1'b0, 4'h3, 16'h0);
    tick();
    set_ch(0, 1'b0, 1'b0, 4'h0, 16'h0);
    reset_N = 1'b0;
    @(negedge clock);
    chk("t5_flush_a", 32'(ifa.rvalid), 32'h0);
    chk("t5_flush_b", 32'(ifb.rvalid), 32'h0);
    tick();
    @(negedge clock);
    chk("t5_flush_b2", 32'(ifb.rvalid), 32'h0);
    tick();
    reset_N = 1'b1;
    @(negedge clock);
    chk("t6_busy_c", 32'(busy_c), 32'h0);
    chk("t5_flush_a2", 32'(ifa.rvalid), 32'h0);
    count_busy("t5_reclear2", 1);

    // No-clear instance: usable straight out of reset.
    tick();
    set_c(0, 1'b1, 1'b1, 4'h0, 16'h1234);
    @(negedge clock);
    chk("t6_gnt_w", 32'(ifc.gnt), 32'h1);
    tick();
    set_c(0, 1'b1, 1'b0, 4'h0, 16'h0);
    tick();
    set_c(0, 1'b0, 1'b0, 4'h0, 16'h0);
    @(negedge clock);
    chk("t6_rv_c", 32'(ifc.rvalid), 32'h1);
    chk("t6_rd_c", 32'(ifc.rdata),  32'h1234);

    // Random traffic: requests held until granted.
    tick();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (last_gnt[i] || !req[i])
          set_ch(i, ($urandom_range(0, 9) < 6), 1'($urandom),
                 AW'($urandom), DW'($urandom));
      end
      clr = ($urandom_range(0, 299) == 0);
      tick();
    end
    req = '0;
    clr = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
